mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Registers the execute-to-memory bus and accepts the 1-cycle-latency data SRAM read data for the load it issued in EX.
- Performs load byte/halfword extraction and extension, and squashes register-file and HI/LO writes for excepting instructions.
- Drives the writeback bus, the forwarding bus back to decode, and the exception report to CP0.

Parameters:
- EX_TO_MEM_WD, 167, width of incoming bus (shared define)
- MEM_TO_WB_WD, 136, width of writeback bus (shared define)
- MEM_TO_RF_WD, 104, width of forwarding bus (shared define)

Ports:
- clk  in  1  stage clock; the block uses one clock
- resetn  in  1  asynchronous active-low reset
- stall  in  1  1 = hold pipeline register (from the stall controller)
- flush  in  1  1 = squash register contents (exception or eret)
- ex_to_mem_bus  in  167  {excepttype[166:151], mem_op[150:143], hilo_bus[142:77], ex_pc[76:45], data_ram_en[44], data_ram_wen[43], data_ram_sel[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- data_sram_rdata  in  32  SRAM read data; valid only in the cycle after issue
- mem_to_wb_bus  out  136  {hilo_bus 66, mem_pc 32, rf_we 1, rf_waddr 5, rf_wdata 32}
- mem_to_rf_bus  out  104  {hilo_bus 66, rf_we 1, rf_waddr 5, rf_wdata 32}
- excepttype_o  out  16  registered exception vector to CP0
- mem_pc  out  32  PC of the instruction in MEM
- bad_vaddr  out  32  registered ex_result, used for AdEL/AdES

Behaviour:
- Pipeline register:
  - resetn=0 clears it to all-zero asynchronously.
  - On each clk edge, priority is flush > stall > load. flush clears; stall holds; otherwise ex_to_mem_bus is captured.
  - All outputs derive from the register plus the hold logic, so every output is 0 in reset.
- first_cyc flop:
  - Set to 1 on an edge that loads a new instruction, including one whose data_ram_en=0.
  - Cleared on any edge with stall or flush.
  - Reset value 0.
- rdata_hold (32b):
  - Captures data_sram_rdata on any edge where first_cyc=1.
  - Reset value 0.
- Read data selection: rdata_eff = first_cyc ? data_sram_rdata : rdata_hold. This guarantees correct load data under a stall of any length after the SRAM output has changed.
- mem_op bit order [7:0] = {lb, lbu, lh, lhu, lw, sb, sh, sw}.
- Load extraction, using ex_result[1:0]:
  - lb/lbu: select byte ex_result[1:0]; sign- or zero-extend.
  - lh/lhu: halfword ex_result[1] ? [31:16] : [15:0]; sign- or zero-extend.
  - lw: whole word.
- rf_wdata = sel_rf_res ? load_data : ex_result. The sel_rf_res=1 value is only meaningful for load ops.
- Exception squash:
  - exc_any = |excepttype (registered).
  - When exc_any=1: output rf_we=0, and both hi_we and lo_we inside the output hilo_bus are forced 0. The data fields pass through unchanged.
- excepttype_o = registered excepttype. mem_pc = registered ex_pc. bad_vaddr = registered ex_result.
- mem_to_rf_bus uses the same rf_we, rf_waddr, rf_wdata and hilo_bus values as mem_to_wb_bus, so forwarding matches commit.
- Boundary cases:
  - flush and stall in the same cycle: flush wins. first_cyc becomes 0 and the register becomes zero (a bubble).
  - Misaligned lw: the data path is still computed, but rf_we is suppressed by the AdEL bit (excepttype bit 7).
  - Reset mid-stall: everything is cleared; no stale rdata_hold is used, because first_cyc=0 and the register is zero.
- Latency: 1 cycle from the EX bus to the outputs. The block generates no stall request of its own.

Decomposition:
- defines.vh gets: EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_RF_WD, HILO_WD, EXCEPTTYPE_WD, and the mem_op bit-position constants.
- One natural sub-module: load_align (combinational; inputs rdata_eff, addr[1:0], mem_op; output load_data).
- The pipeline register, first_cyc and rdata_hold stay in mem_stage.

Test Plan:
- lb, ex_result=0x1003, rdata=0x80FF_1234, no stall -> rf_wdata=0xFFFF_FF80, rf_we=1 one cycle after capture.
- lhu, ex_result=0x1002, rdata=0x8001_5678 -> rf_wdata=0x0000_8001. lh at 0x1000, same data -> 0x0000_5678.
- lw, stall held 3 cycles after capture; rdata=0xDEAD_BEEF in first cycle, then 0x0 -> rf_wdata stays 0xDEAD_BEEF throughout.
- Bus with excepttype bit 7 set, rf_we=1, hi_we=1 -> output rf_we=0, hi_we=0, excepttype_o bit7=1, bad_vaddr=ex_result.
- flush and stall asserted together with a valid load in MEM -> next cycle all bus outputs 0, first_cyc=0.
- resetn pulsed low mid-stall with a load held -> all outputs 0 immediately (asynchronously); after release, a new lw returns fresh rdata.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and mem_op bit positions for the memory stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD  = 167;
    localparam int MEM_TO_WB_WD  = 136;
    localparam int MEM_TO_RF_WD  = 104;
    localparam int HILO_WD       = 66;
    localparam int EXCEPTTYPE_WD = 16;

    localparam int OP_LB  = 7;
    localparam int OP_LBU = 6;
    localparam int OP_LH  = 5;
    localparam int OP_LHU = 4;
    localparam int OP_LW  = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    localparam int EXC_ADEL = 7;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef struct packed {
        logic [EXCEPTTYPE_WD-1:0] excepttype;
        logic [7:0]               mem_op;
        hilo_t                    hilo;
        logic [31:0]              ex_pc;
        logic                     data_ram_en;
        logic                     data_ram_wen;
        logic [3:0]               data_ram_sel;
        logic                     sel_rf_res;
        logic                     rf_we;
        logic [4:0]               rf_waddr;
        logic [31:0]              ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts and extends the loaded byte/halfword/word from the SRAM read word.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_eff,
    input  logic [1:0]  addr,
    input  logic [7:0]  mem_op,
    output logic [31:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr)
            2'd0: byte_sel = rdata_eff[7:0];
            2'd1: byte_sel = rdata_eff[15:8];
            2'd2: byte_sel = rdata_eff[23:16];
            2'd3: byte_sel = rdata_eff[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        if (mem_op[OP_LB])       load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[OP_LBU]) load_data = {24'h0, byte_sel};
        else if (mem_op[OP_LH])  load_data = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[OP_LHU]) load_data = {16'h0, half_sel};
        else if (mem_op[OP_LW])  load_data = rdata_eff;
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, load data capture/alignment,
// exception squash of RF/HI/LO writes, and WB / forwarding / CP0 outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_TO_MEM_WD_P = EX_TO_MEM_WD,
    parameter int MEM_TO_WB_WD_P = MEM_TO_WB_WD,
    parameter int MEM_TO_RF_WD_P = MEM_TO_RF_WD
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [EX_TO_MEM_WD_P-1:0] ex_to_mem_bus,
    input  logic [31:0]               data_sram_rdata,
    output logic [MEM_TO_WB_WD_P-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD_P-1:0] mem_to_rf_bus,
    output logic [15:0]               excepttype_o,
    output logic [31:0]               mem_pc,
    output logic [31:0]               bad_vaddr
);
    ex_to_mem_t  ms;
    logic        first_cyc;
    logic [31:0] rdata_hold;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;
    logic        exc_any;
    logic        rf_we;
    logic [31:0] rf_wdata;
    hilo_t       hilo_out;
    logic        unused_bits;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms         <= '0;
            first_cyc  <= 1'b0;
            rdata_hold <= 32'h0;
        end else begin
            if (flush)       ms <= '0;
            else if (!stall) ms <= ex_to_mem_bus;
            first_cyc <= !(stall || flush);
            // SRAM output is only valid the cycle after issue; keep it for long stalls
            if (first_cyc) rdata_hold <= data_sram_rdata;
        end
    end

    assign rdata_eff = first_cyc ? data_sram_rdata : rdata_hold;

    mem_stage_load_align u_load_align (
        .rdata_eff (rdata_eff),
        .addr      (ms.ex_result[1:0]),
        .mem_op    (ms.mem_op),
        .load_data (load_data)
    );

    assign exc_any  = |ms.excepttype;
    assign rf_we    = ms.rf_we && !exc_any;
    assign rf_wdata = ms.sel_rf_res ? load_data : ms.ex_result;

    always_comb begin
        hilo_out = ms.hilo;
        if (exc_any) begin
            hilo_out.hi_we = 1'b0;
            hilo_out.lo_we = 1'b0;
        end
    end

    assign mem_to_wb_bus = {hilo_out, ms.ex_pc, rf_we, ms.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {hilo_out, rf_we, ms.rf_waddr, rf_wdata};
    assign excepttype_o  = ms.excepttype;
    assign mem_pc        = ms.ex_pc;
    assign bad_vaddr     = ms.ex_result;

    assign unused_bits = ^{ms.data_ram_en, ms.data_ram_wen, ms.data_ram_sel};
endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         resetn;
    logic         stall;
    logic         flush;
    logic [166:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_rf_bus;
    logic [15:0]  excepttype_o;
    logic [31:0]  mem_pc;
    logic [31:0]  bad_vaddr;

    int tests = 0;
    int fails = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .flush           (flush),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus),
        .excepttype_o    (excepttype_o),
        .mem_pc          (mem_pc),
        .bad_vaddr       (bad_vaddr)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] LB = 8'h80, LBU = 8'h40, LH = 8'h20, LHU = 8'h10, LW = 8'h08, NOP = 8'h00;

    function automatic logic [166:0] mk_bus(input logic [15:0] exc, input logic [7:0] op,
                                            input logic [65:0] hilo, input logic [31:0] pc,
                                            input logic selrf, input logic we,
                                            input logic [4:0] waddr, input logic [31:0] res);
        logic ld;
        ld = |op[7:3];
        return {exc, op, hilo, pc, ld, 1'b0, 4'hF, selrf, we, waddr, res};
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic        selrf;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{LB,  1'b1, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1] = '{LHU, 1'b1, 32'h1002, 32'h8001_5678, 32'h0000_8001};
        vecs[2] = '{LH,  1'b1, 32'h1000, 32'h8001_5678, 32'h0000_5678};
        vecs[3] = '{LBU, 1'b1, 32'h1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[4] = '{LB,  1'b1, 32'h1001, 32'h80FF_1234, 32'h0000_0012};
        vecs[5] = '{LH,  1'b1, 32'h1002, 32'h8001_5678, 32'hFFFF_8001};
        vecs[6] = '{LW,  1'b1, 32'h2000, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[7] = '{NOP, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[8] = '{LBU, 1'b1, 32'h1000, 32'h0000_00F0, 32'h0000_00F0};
        vecs[9] = '{LB,  1'b1, 32'h1002, 32'h00FF_0000, 32'hFFFF_FFFF};

        resetn = 1'b0; stall = 1'b0; flush = 1'b0;
        ex_to_mem_bus = '0; data_sram_rdata = 32'h0;
        #12;
        check("reset_wb_bus", mem_to_wb_bus, 136'h0);
        check("reset_rf_bus", {32'h0, mem_to_rf_bus}, 136'h0);
        check("reset_pc_badv_exc", {mem_pc, bad_vaddr, excepttype_o}, 80'h0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            ex_to_mem_bus = mk_bus(16'h0, vecs[i].op, 66'h0, 32'hBFC0_0000 + i * 4,
                                   vecs[i].selrf, 1'b1, 5'(i + 3), vecs[i].addr);
            data_sram_rdata = 32'h0;
            tick();
            data_sram_rdata = vecs[i].rdata;
            ex_to_mem_bus = '0;
            #1;
            check($sformatf("vec%0d_wdata", i), {104'h0, mem_to_wb_bus[31:0]}, {104'h0, vecs[i].exp_wdata});
            check($sformatf("vec%0d_we_waddr_pc", i), {98'h0, mem_to_wb_bus[69:32]},
                  {98'h0, 32'hBFC0_0000 + i * 4, 1'b1, 5'(i + 3)});
            check($sformatf("vec%0d_fwd", i), {96'h0, mem_to_rf_bus[37:0]},
                  {96'h0, 1'b1, 5'(i + 3), vecs[i].exp_wdata});
        end

        // lw held by a 3-cycle stall while the SRAM output changes
        ex_to_mem_bus = mk_bus(16'h0, LW, 66'h0, 32'h8000_0100, 1'b1, 1'b1, 5'd9, 32'h3000);
        tick();
        data_sram_rdata = 32'hDEAD_BEEF;
        stall = 1'b1;
        ex_to_mem_bus = mk_bus(16'h0, LW, 66'h0, 32'h8000_0104, 1'b1, 1'b1, 5'd10, 32'h3004);
        #1;
        check("stall_c0_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'hDEAD_BEEF});
        for (int c = 1; c <= 3; c++) begin
            tick();
            data_sram_rdata = 32'h0;
            #1;
            check($sformatf("stall_c%0d_wdata", c), {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'hDEAD_BEEF});
        end
        check("stall_pc_held", {104'h0, mem_pc}, {104'h0, 32'h8000_0100});
        stall = 1'b0;

        // misaligned lw with AdEL and HI/LO writes pending
        ex_to_mem_bus = mk_bus(16'h0080, LW, {2'b11, 32'h1111_1111, 32'h2222_2222},
                               32'h8000_0200, 1'b1, 1'b1, 5'd4, 32'h0000_1001);
        tick();
        ex_to_mem_bus = '0;
        data_sram_rdata = 32'h5555_AAAA;
        #1;
        check("exc_wb_we", {135'h0, mem_to_wb_bus[37]}, 136'h0);
        check("exc_rf_we", {135'h0, mem_to_rf_bus[37]}, 136'h0);
        check("exc_hilo", {70'h0, mem_to_wb_bus[135:70]}, {70'h0, 2'b00, 32'h1111_1111, 32'h2222_2222});
        check("exc_fwd_hilo", {70'h0, mem_to_rf_bus[103:38]}, {70'h0, 2'b00, 32'h1111_1111, 32'h2222_2222});
        check("exc_type_badv_pc", {56'h0, excepttype_o, bad_vaddr, mem_pc},
              {56'h0, 16'h0080, 32'h0000_1001, 32'h8000_0200});
        check("exc_datapath", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h5555_AAAA});

        // no exception: HI/LO enables pass through
        ex_to_mem_bus = mk_bus(16'h0, NOP, {2'b10, 32'hAAAA_0000, 32'h0000_BBBB},
                               32'h8000_0300, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check("hilo_pass", {70'h0, mem_to_wb_bus[135:70]}, {70'h0, 2'b10, 32'hAAAA_0000, 32'h0000_BBBB});

        // flush together with stall on a valid load -> bubble
        ex_to_mem_bus = mk_bus(16'h0, LW, 66'h0, 32'h8000_0400, 1'b1, 1'b1, 5'd7, 32'h4000);
        tick();
        data_sram_rdata = 32'h7777_7777;
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        ex_to_mem_bus = '0;
        #1;
        check("flush_wb_bus", mem_to_wb_bus, 136'h0);
        check("flush_rf_bus", {32'h0, mem_to_rf_bus}, 136'h0);
        check("flush_first_cyc", {135'h0, dut.first_cyc}, 136'h0);

        // async reset mid-stall, then a fresh load
        ex_to_mem_bus = mk_bus(16'h0, LW, 66'h0, 32'h8000_0500, 1'b1, 1'b1, 5'd8, 32'h5000);
        tick();
        data_sram_rdata = 32'h1357_9BDF;
        stall = 1'b1;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_wb", mem_to_wb_bus, 136'h0);
        check("rst_async_misc", {56'h0, excepttype_o, mem_pc, bad_vaddr}, 136'h0);
        @(negedge clk);
        resetn = 1'b1;
        stall = 1'b0;
        ex_to_mem_bus = mk_bus(16'h0, LW, 66'h0, 32'h8000_0600, 1'b1, 1'b1, 5'd11, 32'h6000);
        data_sram_rdata = 32'h0;
        tick();
        ex_to_mem_bus = '0;
        data_sram_rdata = 32'h2468_ACE0;
        #1;
        check("rst_fresh_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h2468_ACE0});
        check("rst_fresh_we", {98'h0, mem_to_wb_bus[69:32]}, {98'h0, 32'h8000_0600, 1'b1, 5'd11});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
